// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for arbiters that schedule bytes onto the single UART transmitter.
// Holds the state encoding, the default watchdog limit and the baud-tick constants.
package uart_tx_arbiter_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_START     = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE      = ST_IDLE,
        S_START     = ST_START,
        S_WAIT_BUSY = ST_WAIT_BUSY,
        S_WAIT_DONE = ST_WAIT_DONE
    } arb_state_e;

    localparam int DEFAULT_ACK_TIMEOUT = 16;

    // Baud tick generator runs at 16x the bit rate off the 100 MHz system clock.
    localparam int CLK_FREQ_HZ   = 100_000_000;
    localparam int BAUD_RATE     = 9600;
    localparam int OVERSAMPLE    = 16;
    localparam int BAUD_TICK_DIV = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE);

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request bit after the owner pointer,
// wrapping modulo N_REQ; valid is low when nobody is requesting.
module rr_pick #(
    parameter int N_REQ = 4,
    localparam int OW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [OW-1:0]    owner,
    output logic [OW-1:0]    winner,
    output logic             valid
);

    int idx;

    // Scan farthest offset first so the nearest set bit after owner overwrites the rest.
    always_comb begin
        winner = owner;
        valid  = |req;
        idx    = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(owner) + k) % N_REQ;
            if (req[idx]) begin
                winner = OW'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between N_REQ byte producers,
// with per-owner packet lock and a start-acknowledge watchdog.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 8,
    parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT,
    localparam int OW         = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          lock,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          ack,
    output logic [OW-1:0]             owner,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_start,
    input  logic                      tx_busy,
    output logic                      timeout_err
);

    localparam int CW = $clog2(ACK_TIMEOUT);

    arb_state_e          state_q, state_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic                timeout_err_q, timeout_err_d;
    logic                hold_q, hold_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic [OW-1:0]       rr_winner;
    logic                rr_valid;
    logic [OW-1:0]       win;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req    (req),
        .owner  (owner_q),
        .winner (rr_winner),
        .valid  (rr_valid)
    );

    // A held lock only wins if the owner is still asking; otherwise plain round-robin.
    assign win = (hold_q && req[owner_q]) ? owner_q : rr_winner;

    always_comb begin
        state_d       = state_q;
        ack_d         = '0;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        hold_d        = hold_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            S_IDLE: begin
                hold_d = 1'b0;
                if (rr_valid) begin
                    ack_d      = N_REQ'(1) << win;
                    tx_data_d  = req_data[int'(win)*DATA_W +: DATA_W];
                    owner_d    = win;
                    tx_start_d = 1'b1;
                    state_d    = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == CW'(ACK_TIMEOUT - 2)) begin
                    // Abort lands in IDLE exactly ACK_TIMEOUT cycles after the start edge.
                    timeout_err_d = 1'b1;
                    hold_d        = 1'b0;
                    state_d       = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    hold_d  = lock[owner_q];
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ack_q         <= '0;
            owner_q       <= OW'(N_REQ - 1);
            tx_data_q     <= '0;
            tx_start_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            hold_q        <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            ack_q         <= ack_d;
            owner_q       <= owner_d;
            tx_data_q     <= tx_data_d;
            tx_start_q    <= tx_start_d;
            timeout_err_q <= timeout_err_d;
            hold_q        <= hold_d;
            cnt_q         <= cnt_d;
        end
    end

    assign ack         = ack_q;
    assign owner       = owner_q;
    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: grants, round-robin order, lock hold,
// watchdog abort, asynchronous reset and back-to-back start spacing.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [1:0]  owner;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        timeout_err;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int last_start = 0;
    int prev_start = 0;

    uart_tx_arbiter #(
        .N_REQ       (4),
        .DATA_W      (8),
        .ACK_TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .lock        (lock),
        .req_data    (req_data),
        .ack         (ack),
        .owner       (owner),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        $display("check %-14s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic wait_start(input string tag, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < 64 && !ok) begin
            @(negedge clk);
            if (tx_start === 1'b1) ok = 1'b1;
            n++;
        end
        check({tag, "_seen"}, 32'(ok), 32'd1);
    endtask

    // One transfer: wait for the start strobe, check it, then model a busy frame.
    task automatic serve(input string tag, input logic [3:0] exp_ack, input logic [7:0] exp_data,
                         input logic [1:0] exp_owner, input int busy_len, input bit clr);
        bit ok;
        wait_start(tag, ok);
        if (ok) begin
            check({tag, "_ack"}, 32'(ack), 32'(exp_ack));
            check({tag, "_data"}, 32'(tx_data), 32'(exp_data));
            check({tag, "_owner"}, 32'(owner), 32'(exp_owner));
            prev_start = last_start;
            last_start = cyc;
            if (clr) req = req & ~exp_ack;
            @(negedge clk);
            check({tag, "_pulse"}, 32'({ack, tx_start}), 32'd0);
            tx_busy = 1'b1;
            repeat (busy_len) @(negedge clk);
            tx_busy = 1'b0;
        end
    endtask

    initial begin
        bit ok;
        int t0;
        int n;

        rst_n    = 1'b0;
        req      = 4'b0000;
        lock     = 4'b0000;
        tx_busy  = 1'b0;
        req_data = {8'h13, 8'h12, 8'h11, 8'h41};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_start", 32'(tx_start), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_owner", 32'(owner), 32'd3);
        check("rst_to", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;

        // Single request, busy 10 cycles; next start 13 cycles later shows the 1-cycle IDLE return
        req = 4'b0001;
        serve("t1_a", 4'b0001, 8'h41, 2'd0, 10, 1'b1);
        req = 4'b1000;
        serve("t1_b", 4'b1000, 8'h13, 2'd3, 4, 1'b1);
        check("t1_spacing", 32'(last_start - prev_start), 32'd13);

        // All four requesting: strict rotation starting at 0
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req      = 4'b1111;
        serve("rr_0", 4'b0001, 8'h10, 2'd0, 3, 1'b0);
        serve("rr_1", 4'b0010, 8'h11, 2'd1, 3, 1'b0);
        serve("rr_2", 4'b0100, 8'h12, 2'd2, 3, 1'b0);
        serve("rr_3", 4'b1000, 8'h13, 2'd3, 3, 1'b0);
        serve("rr_4", 4'b0001, 8'h10, 2'd0, 3, 1'b0);

        // Requester 2 locks a three-byte packet while everyone keeps requesting
        lock = 4'b0100;
        serve("lk_1", 4'b0010, 8'h11, 2'd1, 3, 1'b0);
        serve("lk_2a", 4'b0100, 8'h12, 2'd2, 3, 1'b0);
        serve("lk_2b", 4'b0100, 8'h12, 2'd2, 3, 1'b0);
        serve("lk_2c", 4'b0100, 8'h12, 2'd2, 3, 1'b0);
        lock = 4'b0000;
        serve("lk_3", 4'b1000, 8'h13, 2'd3, 3, 1'b0);
        req = 4'b0000;

        // Watchdog: transmitter never goes busy
        req = 4'b0001;
        wait_start("to", ok);
        check("to_ack", 32'(ack), 32'b0001);
        t0  = cyc;
        req = 4'b0000;
        n   = 0;
        while (n < 40 && timeout_err !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        check("to_delay", 32'(cyc - t0), 32'd16);
        repeat (5) @(negedge clk);
        check("to_sticky", 32'(timeout_err), 32'd1);
        req = 4'b0010;
        serve("to_next", 4'b0010, 8'h11, 2'd1, 3, 1'b1);
        check("to_still", 32'(timeout_err), 32'd1);

        // Asynchronous reset while waiting for the frame to finish
        req = 4'b0001;
        wait_start("ar", ok);
        req = 4'b0000;
        @(negedge clk);
        tx_busy = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_ack", 32'(ack), 32'd0);
        check("ar_start", 32'(tx_start), 32'd0);
        check("ar_to", 32'(timeout_err), 32'd0);
        check("ar_owner", 32'(owner), 32'd3);
        check("ar_data", 32'(tx_data), 32'd0);
        @(negedge clk);
        tx_busy = 1'b0;
        rst_n   = 1'b1;
        req     = 4'b0100;
        serve("ar_post", 4'b0100, 8'h12, 2'd2, 3, 1'b1);

        // Single requester held: re-granted every frame, spacing busy + 3
        req = 4'b0010;
        serve("hold_a", 4'b0010, 8'h11, 2'd1, 5, 1'b0);
        serve("hold_b", 4'b0010, 8'h11, 2'd1, 5, 1'b0);
        check("hold_sp1", 32'(last_start - prev_start), 32'd8);
        serve("hold_c", 4'b0010, 8'h11, 2'd1, 5, 1'b0);
        check("hold_sp2", 32'(last_start - prev_start), 32'd8);
        req = 4'b0000;

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
